// File: rtl/logic_gate_unit.sv
// Bitwise AND2/AND3/OR3 gate bank: zero-latency combinational outputs plus a
// one-cycle registered, op-selected result with valid and any/all reduction flags.

module logic_gate_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_and2,
    output logic o_and3,
    output logic o_or3
);
    // AND2 never looks at i_c, so an unknown on operand 2 cannot leak into it.
    assign o_and2 = i_a & i_b;
    assign o_and3 = i_a & i_b & i_c;
    assign o_or3  = i_a | i_b | i_c;
endmodule

module logic_gate_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] and2_out,
    output logic [WIDTH-1:0] and3_out,
    output logic [WIDTH-1:0] or3_out,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_any,
    output logic             out_all
);
    localparam logic [1:0] OP_AND2 = 2'b00;
    localparam logic [1:0] OP_AND3 = 2'b01;
    localparam logic [1:0] OP_OR3  = 2'b10;

    logic [WIDTH-1:0] w_and2;
    logic [WIDTH-1:0] w_and3;
    logic [WIDTH-1:0] w_or3;
    logic [WIDTH-1:0] w_sel;

    logic [WIDTH-1:0] r_out;
    logic             r_vld;
    logic             r_any;
    logic             r_all;

    // One slice per bit keeps every output bit tied to its own input bit only.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            logic_gate_slice u_slice (
                .i_a    (in0[g]),
                .i_b    (in1[g]),
                .i_c    (in2[g]),
                .o_and2 (w_and2[g]),
                .o_and3 (w_and3[g]),
                .o_or3  (w_or3[g])
            );
        end
    endgenerate

    assign and2_out = w_and2;
    assign and3_out = w_and3;
    assign or3_out  = w_or3;

    // Reserved op still counts as a sample; it just produces zeros.
    always_comb begin
        w_sel = '0;
        case (op)
            OP_AND2: w_sel = w_and2;
            OP_AND3: w_sel = w_and3;
            OP_OR3:  w_sel = w_or3;
            default: w_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_vld <= 1'b0;
            r_any <= 1'b0;
            r_all <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_out <= w_sel;
                r_any <= |w_sel;
                r_all <= &w_sel;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_vld;
    assign out_any   = r_any;
    assign out_all   = r_all;
endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: WIDTH=8 registered/comb paths plus a
// WIDTH=1 instance for the exhaustive truth table.

module tb_logic_gate_unit;
    typedef struct packed {
        logic [7:0] out;
        logic       any;
        logic       all;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0;
    logic [7:0] and2_out, and3_out, or3_out, out;
    logic       out_valid, out_any, out_all;

    logic       v1 = 1'b0;
    logic [1:0] op1 = 2'b00;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       and2_1, and3_1, or3_1, out_1, vld_1, any_1, all_1;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t last = '0;
    logic tb_pend = 1'b0;

    always #5 clk = ~clk;

    logic_gate_unit #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
        .in0(in0), .in1(in1), .in2(in2),
        .and2_out(and2_out), .and3_out(and3_out), .or3_out(or3_out),
        .out(out), .out_valid(out_valid), .out_any(out_any), .out_all(out_all)
    );

    logic_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .op(op1),
        .in0(a1), .in1(b1), .in2(c1),
        .and2_out(and2_1), .and3_out(and3_1), .or3_out(or3_1),
        .out(out_1), .out_valid(vld_1), .out_any(any_1), .out_all(all_1)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [7:0] a,
                                   input logic [7:0] b, input logic [7:0] c);
        exp_t e;
        case (o)
            2'b00:   e.out = a & b;
            2'b01:   e.out = a & b & c;
            2'b10:   e.out = a | b | c;
            default: e.out = 8'h00;
        endcase
        e.any = (e.out != 8'h00);
        e.all = (e.out == 8'hFF);
        return e;
    endfunction

    // Expected acceptance: a sample taken on an edge with reset low.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_pend <= 1'b0;
        else     tb_pend <= in_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_out", out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_flags", {out_any, out_all}, 0);
            last = '0;
        end else begin
            chk("valid", out_valid, tb_pend);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out", out, e.out);
                    chk("any", out_any, e.any);
                    chk("all", out_all, e.all);
                    last = e;
                end
            end else begin
                chk("hold", {out, out_any, out_all}, {last.out, last.any, last.all});
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        in_valid = 1'b1;
        op = o; in0 = a; in1 = b; in2 = c;
        exp_q.push_back(model(o, a, b, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [2:0] v;
        logic [1:0] sops [4];
        sops[0] = 2'b00; sops[1] = 2'b01; sops[2] = 2'b10; sops[3] = 2'b00;

        #1 rst = 1'b1;
        in0 = 8'hF0; in1 = 8'hCC; in2 = 8'hAA;
        #1;
        chk("comb_and2_rst", and2_out, 8'hC0);
        chk("comb_and3_rst", and3_out, 8'h80);
        chk("comb_or3_rst", or3_out, 8'hFE);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(2'b00, 8'hF0, 8'hCC, 8'hAA);
        idle(1);
        drive(2'b01, 8'hF0, 8'hCC, 8'hAA);
        drive(2'b10, 8'hF0, 8'hCC, 8'hAA);
        idle(1);
        drive(2'b01, 8'hFF, 8'hFF, 8'hFF);
        drive(2'b10, 8'h00, 8'h00, 8'h00);
        idle(1);
        drive(2'b11, 8'hF0, 8'hCC, 8'hAA);
        idle(3);

        for (int i = 0; i < 4; i++)
            drive(sops[i], 8'($urandom), 8'($urandom), 8'($urandom));
        idle(2);

        // Async reset mid-cycle while a result is valid; pending result is lost.
        drive(2'b01, 8'hFF, 8'hFF, 8'hFF);
        #2;
        chk("pre_rst_out", out, 8'hFF);
        rst = 1'b1;
        exp_q.delete();
        in0 = 8'h0F; in1 = 8'h3C; in2 = 8'h55;
        #1;
        chk("async_rst_out", out, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_flags", {out_any, out_all}, 0);
        chk("comb_and2_rst2", and2_out, 8'h0C);
        chk("comb_and3_rst2", and3_out, 8'h04);
        chk("comb_or3_rst2", or3_out, 8'h7F);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {c1, b1, a1} = v;
            #1;
            chk("tt_and2", and2_1, (v[1:0] == 2'b11));
            chk("tt_and3", and3_1, (v == 3'b111));
            chk("tt_or3", or3_1, (v != 3'b000));
        end
        v1 = 1'b1; op1 = 2'b10; {c1, b1, a1} = 3'b001;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("w1_out", out_1, 1);
        chk("w1_valid", vld_1, 1);
        chk("w1_flags", {any_1, all_1}, 2'b11);

        idle(2);
        chk("q_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Registered bank of the team's basic multi-input gates: 2-input AND, 3-input AND and 3-input OR, applied bitwise over WIDTH-bit operands.
- Provides zero-latency combinational gate outputs for direct netlist use.
- Provides a one-cycle registered, op-selected result with valid and reduction flags.
- Serves as the shared gate primitive for the arithmetic stages (signal counting, parity, zero/four detection).

Parameters:
- WIDTH, 8, bit width of every operand and result vector (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op sample strobe
- op  input  2  registered-path select: 00 AND2, 01 AND3, 10 OR3, 11 reserved
- in0  input  WIDTH  operand 0
- in1  input  WIDTH  operand 1
- in2  input  WIDTH  operand 2 (ignored by AND2)
- and2_out  output  WIDTH  combinational in0 & in1
- and3_out  output  WIDTH  combinational in0 & in1 & in2
- or3_out  output  WIDTH  combinational in0 | in1 | in2
- out  output  WIDTH  registered selected result
- out_valid  output  1  registered; high one cycle per accepted sample
- out_any  output  1  registered; OR-reduction of the value loaded into out
- out_all  output  1  registered; AND-reduction of the value loaded into out

Behaviour:
- Combinational outputs
  - and2_out, and3_out and or3_out are purely combinational, bitwise, with no clock dependence.
  - They are valid during reset.
  - Each bit depends only on the same bit index of the inputs; there is no cross-bit interaction.
- Reset
  - While rst is high, out = 0, out_valid = 0, out_any = 0, out_all = 0, immediately and without waiting for a clock edge.
  - Deassertion takes effect at the next rising clk edge.
  - A sample presented during reset is dropped.
- Latency
  - On a rising clk edge with rst low and in_valid high, out loads the selected result.
  - The selection is: op 00 -> in0&in1; op 01 -> in0&in1&in2; op 10 -> in0|in1|in2; op 11 -> all zeros.
  - out_valid = 1 in the following cycle (1-cycle latency).
  - out_any and out_all are computed from the new result and load in the same edge.
- Hold
  - On a rising edge with in_valid low, out, out_any and out_all hold their value.
  - out_valid = 0.
- Throughput
  - One sample per cycle. Back-to-back in_valid yields back-to-back out_valid with no bubbles.
- op 11 (reserved)
  - Counts as an accepted sample: out_valid = 1, out = 0, out_any = 0, out_all = 0.
- WIDTH = 1
  - out_any = out_all = out[0].
- No X propagation
  - X on in2 must not affect AND2 results.
- Reset mid-stream
  - Asserting rst while out_valid is high clears everything in the same cycle.
  - The pending result is lost.

Test Plan:
- Reset: assert rst asynchronously between edges with out = 8'hFF -> out, out_valid, out_any and out_all drop to 0 before the next edge. Combinational outputs still track their inputs during reset.
- Exhaustive truth table (WIDTH=1): sweep all 8 combinations of in0/in1/in2.
  - and2_out is 1 only when in0 = in1 = 1.
  - and3_out is 1 only for 111.
  - or3_out is 0 only for 000.
- Registered ops (WIDTH=8, in0=8'hF0, in1=8'hCC, in2=8'hAA):
  - op 00 -> out 8'hC0, out_any 1, out_all 0.
  - op 01 -> out 8'h80.
  - op 10 -> out 8'hFE.
  - Each result appears exactly one cycle after its in_valid.
- All-ones/all-zeros: op 01 with all operands 8'hFF -> out 8'hFF, out_all 1. Then op 10 with all operands 8'h00 -> out 8'h00, out_any 0.
- Reserved/hold: op 11 with in_valid -> out 0, out_valid 1. Then 3 cycles of in_valid low -> out holds 0, out_valid 0.
- Streaming: 4 back-to-back samples cycling op 00/01/10/00 with in_valid high -> 4 consecutive out_valid pulses with matching results in order.
